// File: rtl/sensor_uart_pkg.sv
// Shared types and constants for the sensor-to-UART bridge.
// UART_PARITY_EN adds the PARITY state to the transmitter state type.
package sensor_uart_pkg;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  localparam logic [3:0] HDR_NIBBLE = 4'hA;
  localparam int         CH_ID_W    = 4;
  localparam int         DROP_CNT_W = 16;

endpackage

// File: rtl/sensor_uart_fifo.sv
// Synchronous sample FIFO with combinational read port and full/empty/level outputs.
// A push and pop together while empty passes wr_data straight through.
module sensor_uart_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             bypass, do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = empty ? wr_data : mem_q[rd_ptr_q];

  always_comb begin
    bypass   = push && pop && empty;
    do_push  = push && (!full || pop) && !bypass;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
    else if (do_pop && !do_push) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sensor_uart_bridge.sv
// Multi-channel sensor bridge: hold regs + round-robin arbiter feed a sample FIFO that a
// framed UART transmitter drains. Define UART_PARITY_EN for 8E1 frames, otherwise 8N1.
module sensor_uart_bridge
  import sensor_uart_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH*DATA_W-1:0]      ch_data,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_CNT_W-1:0]         drop_cnt
);
  localparam int ENTRY_W = CH_ID_W + DATA_W;
  localparam int PKT_W   = 8 + DATA_W;
  localparam int NBYTES  = DATA_W / 8;
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int IDX_W   = CH_ID_W + 1;

  logic [NUM_CH-1:0]     pending_q, pending_d;
  logic [DATA_W-1:0]     hold_q [NUM_CH];
  logic [DATA_W-1:0]     hold_d [NUM_CH];
  logic [CH_ID_W-1:0]    rr_q, rr_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [IDX_W-1:0]      drop_inc, cand;
  logic                  grant;
  logic [CH_ID_W-1:0]    gnt_idx;
  logic [ENTRY_W-1:0]    push_data, rd_data;
  logic                  fifo_full, fifo_empty, pop;

  tx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [2:0]            byte_idx_q, byte_idx_d;
  logic [PKT_W-1:0]      pkt_q, pkt_d;
  logic                  uart_q, uart_d, busy_q, busy_d;
  logic [7:0]            cur_byte;
  logic                  tick;

  // Round-robin: first pending channel at or after rr_q, only when the FIFO can accept.
  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_q} + IDX_W'(i);
      if (cand >= IDX_W'(NUM_CH)) cand = cand - IDX_W'(NUM_CH);
      for (int k = 0; k < NUM_CH; k++) begin
        if (!grant && !fifo_full && pending_q[k] && cand == IDX_W'(k)) begin
          grant   = 1'b1;
          gnt_idx = CH_ID_W'(k);
        end
      end
    end
  end

  // The granted (old) sample is pushed before a same-cycle strobe refills the hold reg.
  always_comb begin
    push_data = '0;
    pending_d = pending_q;
    rr_d      = rr_q;
    drop_inc  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hold_d[k] = hold_q[k];
      if (grant && gnt_idx == CH_ID_W'(k)) begin
        push_data    = {CH_ID_W'(k), hold_q[k]};
        pending_d[k] = 1'b0;
      end
      if (ch_valid[k]) begin
        hold_d[k] = ch_data[k*DATA_W +: DATA_W];
        if (pending_q[k] && !(grant && gnt_idx == CH_ID_W'(k))) drop_inc = drop_inc + IDX_W'(1);
        pending_d[k] = 1'b1;
      end
    end
    if (grant) rr_d = (gnt_idx == CH_ID_W'(NUM_CH-1)) ? '0 : gnt_idx + CH_ID_W'(1);
    drop_sum = {1'b0, drop_q} + (DROP_CNT_W+1)'(drop_inc);
    drop_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      rr_q      <= '0;
      drop_q    <= '0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      drop_q    <= drop_d;
    end
    hold_q <= hold_d;
  end

  sensor_uart_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (grant),
    .pop     (pop),
    .wr_data (push_data),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign cur_byte = pkt_q[PKT_W-1 -: 8];
  assign tick     = (bit_cnt_q == CNT_W'(CLKS_PER_BIT-1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    pkt_d      = pkt_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          pkt_d      = {HDR_NIBBLE, rd_data};
          byte_idx_d = '0;
          state_d    = START;
        end
      end
      START: if (tick) begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        state_d   = DATA;
      end
      DATA: if (tick) begin
        bit_cnt_d = '0;
        if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (tick) begin
        bit_cnt_d = '0;
        state_d   = STOP;
      end
`endif
      STOP: if (tick) begin
        bit_cnt_d = '0;
        if (byte_idx_q == 3'(NBYTES)) begin
          state_d = IDLE;
        end else begin
          byte_idx_d = byte_idx_q + 3'd1;
          pkt_d      = pkt_q << 8;
          state_d    = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and busy are registered from the state, so both lag the FSM by one cycle.
  always_comb begin
    uart_d = 1'b1;
    case (state_q)
      START:  uart_d = 1'b0;
      DATA:   uart_d = cur_byte[bit_idx_q];
`ifdef UART_PARITY_EN
      PARITY: uart_d = ^cur_byte;
`endif
      default: uart_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      uart_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      uart_q     <= uart_d;
      busy_q     <= busy_d;
    end
    pkt_q <= pkt_d;
  end

  assign uart_tx  = uart_q;
  assign tx_busy  = busy_q;
  assign drop_cnt = drop_q;

endmodule
